// File: rtl/spi_byte_master.sv
// Byte-wide SPI master: shifts one byte MSB-first per accepted strobe and returns the byte seen on MISO.
// Optional SPI_3WIRE_EN: byte index under chip select; SDIO is released for the data phase of reads.
module spi_byte_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter bit          CPOL    = 1'b0,
  parameter bit          CPHA    = 1'b0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] spitx,
  input  logic       spitxdv,
  output logic       spitxready,
  output logic [7:0] spirx,
  output logic       spirxdv,
  output logic       sclk,
  output logic       mosi,
`ifdef SPI_3WIRE_EN
  input  logic       spi_cs_n,
  output logic       sdio_oe,
`endif
  input  logic       miso
);

  localparam int unsigned DW     = 8;
  localparam int unsigned DIV_W  = 8;
  localparam int unsigned EDGE_W = 4;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(15);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic [DW-1:0]     tx_q, tx_d;
  logic [DW-1:0]     rx_q, rx_d;
  logic [DW-1:0]     spirx_q, spirx_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              ready_q, ready_d;
  logic              rxdv_q, rxdv_d;
  logic              accept, tick, last, leading, sample;

  assign accept  = spitxdv && ready_q;
  assign tick    = (state_q == SHIFT) && (div_q == DIV_LAST);
  assign last    = tick && (edge_q == EDGE_LAST);
  // edge_q holds the number of SCLK edges already issued; even count means the next edge is leading
  assign leading = ~edge_q[0];
  assign sample  = leading ^ CPHA;

`ifdef SPI_3WIRE_EN
  logic [1:0] idx_q, idx_d;
  logic       rd_q, rd_d;
  logic       oe_q, oe_d;
  logic       rd_byte;

  // Byte index saturates at 2: only "data phase or not" matters
  always_comb begin
    idx_d = idx_q;
    rd_d  = rd_q;
    if (spi_cs_n) begin
      idx_d = 2'd0;
    end else if ((state_q == DONE) && (idx_q != 2'd2)) begin
      idx_d = idx_q + 2'd1;
    end
    if (accept && (idx_d == 2'd0)) begin
      rd_d = spitx[DW-1];
    end
  end

  assign rd_byte = rd_d && (idx_d == 2'd2);
  assign oe_d    = ((state_d == SHIFT) && !rd_byte) || (state_d == DONE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      idx_q <= 2'd0;
      rd_q  <= 1'b0;
      oe_q  <= 1'b0;
    end else begin
      idx_q <= idx_d;
      rd_q  <= rd_d;
      oe_q  <= oe_d;
    end
  end

  assign sdio_oe = oe_q;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (last) state_d = DONE;
      DONE:    state_d = accept ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Divider, edge counter, shift registers and registered outputs
  always_comb begin
    div_d   = div_q;
    edge_d  = edge_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    spirx_d = spirx_q;
    rxdv_d  = 1'b0;
    ready_d = (state_d != SHIFT);

    if (state_q == SHIFT) begin
      if (tick) begin
        div_d  = '0;
        sclk_d = ~sclk_q;
        edge_d = edge_q + EDGE_W'(1);
        if (sample) begin
          rx_d = {rx_q[DW-2:0], miso};
        end else if (!last) begin
          mosi_d = tx_q[DW-1];
          tx_d   = {tx_q[DW-2:0], 1'b0};
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
      if (last) begin
        spirx_d = rx_d;
        rxdv_d  = 1'b1;
      end
    end

    // With CPHA=0 bit 7 is presented straight away, so the shift register starts at bit 6
    if (accept) begin
      div_d  = '0;
      edge_d = '0;
      rx_d   = '0;
      if (CPHA) begin
        tx_d = spitx;
      end else begin
        tx_d   = {spitx[DW-2:0], 1'b0};
        mosi_d = spitx[DW-1];
      end
    end

`ifdef SPI_3WIRE_EN
    if ((state_d == SHIFT) && rd_byte) begin
      mosi_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      div_q   <= '0;
      edge_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      sclk_q  <= CPOL;
      mosi_q  <= 1'b0;
      ready_q <= 1'b1;
      spirx_q <= '0;
      rxdv_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      edge_q  <= edge_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ready_q <= ready_d;
      spirx_q <= spirx_d;
      rxdv_q  <= rxdv_d;
    end
  end

  assign spitxready = ready_q;
  assign spirx      = spirx_q;
  assign spirxdv    = rxdv_q;
  assign sclk       = sclk_q;
  assign mosi       = mosi_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// Bench for spi_byte_master: master 0 is mode 0 / CLK_DIV=4, master 1 is mode 3 / CLK_DIV=1,
// both checked against a slave-side model that watches SCLK edges.
module tb_spi_byte_master;

  localparam int unsigned NREC = 64;
  localparam int unsigned DIV0 = 4;
  localparam int unsigned DIV1 = 1;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] spitx      [2];
  logic       spitxdv    [2];
  logic       spitxready [2];
  logic [7:0] spirx      [2];
  logic       spirxdv    [2];
  logic       sclk       [2];
  logic       mosi       [2];
  logic       miso       [2];
`ifdef SPI_3WIRE_EN
  logic       cs_n       [2];
  logic       sdio_oe    [2];
`endif

  spi_byte_master #(.CLK_DIV(DIV0), .CPOL(1'b0), .CPHA(1'b0)) u_m0 (
    .clk(clk), .rstn(rstn),
    .spitx(spitx[0]), .spitxdv(spitxdv[0]), .spitxready(spitxready[0]),
    .spirx(spirx[0]), .spirxdv(spirxdv[0]),
    .sclk(sclk[0]), .mosi(mosi[0]),
`ifdef SPI_3WIRE_EN
    .spi_cs_n(cs_n[0]), .sdio_oe(sdio_oe[0]),
`endif
    .miso(miso[0])
  );

  spi_byte_master #(.CLK_DIV(DIV1), .CPOL(1'b1), .CPHA(1'b1)) u_m1 (
    .clk(clk), .rstn(rstn),
    .spitx(spitx[1]), .spitxdv(spitxdv[1]), .spitxready(spitxready[1]),
    .spirx(spirx[1]), .spirxdv(spirxdv[1]),
    .sclk(sclk[1]), .mosi(mosi[1]),
`ifdef SPI_3WIRE_EN
    .spi_cs_n(cs_n[1]), .sdio_oe(sdio_oe[1]),
`endif
    .miso(miso[1])
  );

  function automatic bit cpol_of(input int d);
    return (d == 1);
  endfunction

  function automatic bit cpha_of(input int d);
    return (d == 1);
  endfunction

  function automatic int lat_of(input int d);
    return 1 + 16 * ((d == 0) ? int'(DIV0) : int'(DIV1));
  endfunction

  // Slave model state and per-byte records (written only by the monitor)
  logic       prev_sclk [2] = '{1'b0, 1'b1};
  int         edges     [2] = '{0, 0};
  int         cyc       [2] = '{0, 0};
  logic [7:0] slave_rx  [2] = '{8'h00, 8'h00};
  logic [7:0] cur_miso  [2] = '{8'h00, 8'h00};
  int         gcyc          = 0;
  int         rec_lat   [2][NREC];
  logic [7:0] rec_rx    [2][NREC];
  logic [7:0] rec_slv   [2][NREC];
  int         rec_edges [2][NREC];
  int         rec_g     [2][NREC];
  int         n_rec     [2] = '{0, 0};

  // Written only by the stimulus block
  logic [7:0] miso_nxt [2];
  logic [7:0] ex_tx    [2][NREC];
  logic [7:0] ex_mi    [2][NREC];
  int         n_ex     [2] = '{0, 0};
  int         checks = 0;
  int         errors = 0;

  always @(negedge clk) begin
    int bi;
    gcyc++;
    for (int d = 0; d < 2; d++) begin
      cyc[d]++;
      if (sclk[d] !== prev_sclk[d]) begin
        edges[d]++;
        if ((prev_sclk[d] === cpol_of(d)) ^ cpha_of(d))
          slave_rx[d] = {slave_rx[d][6:0], mosi[d]};
        prev_sclk[d] = sclk[d];
      end
      if (spirxdv[d] === 1'b1 && n_rec[d] < int'(NREC)) begin
        rec_lat[d][n_rec[d]]   = cyc[d];
        rec_rx[d][n_rec[d]]    = spirx[d];
        rec_slv[d][n_rec[d]]   = slave_rx[d];
        rec_edges[d][n_rec[d]] = edges[d];
        rec_g[d][n_rec[d]]     = gcyc;
        n_rec[d]++;
      end
      if (spitxdv[d] === 1'b1 && spitxready[d] === 1'b1) begin
        cyc[d]      = 0;
        edges[d]    = 0;
        slave_rx[d] = 8'h00;
        cur_miso[d] = miso_nxt[d];
      end
      // Slave presents a new bit after every second SCLK edge, MSB first
      bi = 7 - (((edges[d] / 2) > 7) ? 7 : (edges[d] / 2));
      miso[d] = cur_miso[d][bi];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int d, input logic [7:0] tx, input logic [7:0] mi);
    int n;
    n = 0;
    while (spitxready[d] !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (spitxready[d] !== 1'b1) begin
      chk($sformatf("d%0d_ready_timeout", d), 32'(spitxready[d]), 32'd1);
      return;
    end
    miso_nxt[d]        = mi;
    spitx[d]           = tx;
    spitxdv[d]         = 1'b1;
    ex_tx[d][n_ex[d]]  = tx;
    ex_mi[d][n_ex[d]]  = mi;
    n_ex[d]++;
    @(posedge clk); #1;
    spitxdv[d] = 1'b0;
    spitx[d]   = 8'($urandom);
  endtask

  task automatic wait_rec(input int d, input int target);
    int n;
    n = 0;
    while (n_rec[d] < target && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("d%0d_rx_wait", d), 32'(n_rec[d] >= target), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int d;
    int gap;
    for (int i = 0; i < 2; i++) begin
      spitx[i]    = 8'h00;
      spitxdv[i]  = 1'b0;
      miso_nxt[i] = 8'h00;
`ifdef SPI_3WIRE_EN
      cs_n[i]     = 1'b1;
`endif
    end
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d_rst_sclk", i),  32'(sclk[i]),       32'(cpol_of(i)));
      chk($sformatf("d%0d_rst_mosi", i),  32'(mosi[i]),       32'd0);
      chk($sformatf("d%0d_rst_ready", i), 32'(spitxready[i]), 32'd1);
      chk($sformatf("d%0d_rst_spirx", i), 32'(spirx[i]),      32'd0);
      chk($sformatf("d%0d_rst_rxdv", i),  32'(spirxdv[i]),    32'd0);
`ifdef SPI_3WIRE_EN
      chk($sformatf("d%0d_rst_oe", i),    32'(sdio_oe[i]),    32'd0);
`endif
    end
    rstn = 1'b1;
    @(posedge clk); #1;

    // Mode 0 single byte
    send(0, 8'hA5, 8'h3C);
    wait_rec(0, 1);
    chk("m0_lat",  32'(rec_lat[0][0]), 32'd65);
    chk("m0_rx",   32'(rec_rx[0][0]),  32'h3C);
    chk("m0_mosi", 32'(rec_slv[0][0]), 32'hA5);
    repeat (3) @(posedge clk);
    #1;
    chk("m0_sclk_idle", 32'(sclk[0]),  32'd0);
    chk("m0_mosi_hold", 32'(mosi[0]),  32'd1);
    chk("m0_rx_hold",   32'(spirx[0]), 32'h3C);

    // Back-to-back bytes strobed in DONE
    base = n_rec[0];
    send(0, 8'h01, 8'($urandom));
    send(0, 8'h80, 8'($urandom));
    send(0, 8'hFF, 8'($urandom));
    wait_rec(0, base + 3);
    chk("b2b_gap01", 32'(rec_g[0][base+1] - rec_g[0][base]),   32'd65);
    chk("b2b_gap12", 32'(rec_g[0][base+2] - rec_g[0][base+1]), 32'd65);

    // Strobes while busy are ignored
    base = n_rec[0];
    send(0, 8'hC3, 8'($urandom));
    repeat (9) @(posedge clk);
    #1;
    spitx[0] = 8'h00; spitxdv[0] = 1'b1;
    @(posedge clk); #1;
    spitxdv[0] = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    spitx[0] = 8'h00; spitxdv[0] = 1'b1;
    @(posedge clk); #1;
    spitxdv[0] = 1'b0;
    wait_rec(0, base + 1);
    repeat (80) @(posedge clk);
    #1;
    chk("ign_count", 32'(n_rec[0]), 32'(base + 1));
    chk("ign_mosi",  32'(rec_slv[0][base]), 32'hC3);

    // Mode 3, CLK_DIV=1, MISO tied high
    chk("m3_idle_sclk", 32'(sclk[1]), 32'd1);
    base = n_rec[1];
    send(1, 8'h5A, 8'hFF);
    wait_rec(1, base + 1);
    chk("m3_lat",  32'(rec_lat[1][base]), 32'd17);
    chk("m3_rx",   32'(rec_rx[1][base]),  32'hFF);
    chk("m3_mosi", 32'(rec_slv[1][base]), 32'h5A);

    // Reset at SCLK edge 7 aborts the byte
    base = n_rec[0];
    send(0, 8'h96, 8'h69);
    repeat (27) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    chk("abort_sclk",  32'(sclk[0]),       32'd0);
    chk("abort_ready", 32'(spitxready[0]), 32'd1);
    n_ex[0]--;
    repeat (100) @(posedge clk);
    #1;
    chk("abort_norx", 32'(n_rec[0]), 32'(base));
    send(0, 8'($urandom), 8'($urandom));
    wait_rec(0, n_ex[0]);

    // Random traffic on both masters, sometimes back-to-back or overlapping
    for (int i = 0; i < 16; i++) begin
      d = int'($urandom_range(0, 1));
      send(d, 8'($urandom), 8'($urandom));
      gap = int'($urandom_range(0, 2));
      if (gap != 0) begin
        wait_rec(d, n_ex[d]);
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    wait_rec(0, n_ex[0]);
    wait_rec(1, n_ex[1]);

`ifdef SPI_3WIRE_EN
    cs_n[0] = 1'b0;
    @(posedge clk); #1;
    send(0, 8'h80, 8'($urandom));
    repeat (10) @(posedge clk);
    #1;
    chk("3w_oe_b0", 32'(sdio_oe[0]), 32'd1);
    wait_rec(0, n_ex[0]);
    send(0, 8'h01, 8'($urandom));
    repeat (10) @(posedge clk);
    #1;
    chk("3w_oe_b1", 32'(sdio_oe[0]), 32'd1);
    wait_rec(0, n_ex[0]);
    send(0, 8'h00, 8'h6E);
    repeat (10) @(posedge clk);
    #1;
    chk("3w_oe_b2", 32'(sdio_oe[0]), 32'd0);
    wait_rec(0, n_ex[0]);
    chk("3w_rx_b2", 32'(rec_rx[0][n_rec[0]-1]), 32'h6E);
    send(0, 8'hFF, 8'($urandom));
    ex_tx[0][n_ex[0]-1] = 8'h00;
    repeat (10) @(posedge clk);
    #1;
    chk("3w_oe_b3", 32'(sdio_oe[0]), 32'd0);
    wait_rec(0, n_ex[0]);
    repeat (2) @(posedge clk);
    #1;
    chk("3w_oe_idle", 32'(sdio_oe[0]), 32'd0);
    cs_n[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cs_n[0] = 1'b0;
    @(posedge clk); #1;
    send(0, 8'h00, 8'($urandom));
    repeat (10) @(posedge clk);
    #1;
    chk("3w_oe_new", 32'(sdio_oe[0]), 32'd1);
    wait_rec(0, n_ex[0]);
    cs_n[0] = 1'b1;
`endif

    // Every completed byte against the slave-side expectation
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d_rec_count", k), 32'(n_rec[k]), 32'(n_ex[k]));
      for (int i = 0; i < n_ex[k] && i < n_rec[k]; i++) begin
        chk($sformatf("d%0d_b%0d_lat", k, i),   32'(rec_lat[k][i]),   32'(lat_of(k)));
        chk($sformatf("d%0d_b%0d_rx", k, i),    32'(rec_rx[k][i]),    32'(ex_mi[k][i]));
        chk($sformatf("d%0d_b%0d_mosi", k, i),  32'(rec_slv[k][i]),   32'(ex_tx[k][i]));
        chk($sformatf("d%0d_b%0d_edges", k, i), 32'(rec_edges[k][i]), 32'd16);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
